// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the moving-average FIR engine:
//   - fir_state_e : engine control states (IDLE, CLEAR, RUN)
//   - TAPS        : tap count of the default configuration (2**2)
//   - sumWidth()  : width of the signed running sum for a given sample width
//                   and log2 tap count (wide enough that it never overflows)
// No ports; imported by fir_ma_engine and ma_delay_line.
// ---------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } fir_state_e;

    localparam int TAPS_LOG2_DEFAULT = 2;
    localparam int TAPS              = 1 << TAPS_LOG2_DEFAULT;

    // Summing 2**tapsLog2 samples of dataW bits needs tapsLog2 extra bits.
    function automatic int sumWidth(input int dataW, input int tapsLog2);
        return dataW + tapsLog2;
    endfunction

endpackage

// File: rtl/ma_delay_line.sv
// ---------------------------------------------------------------------------
// ma_delay_line
// Circular buffer of 2**TAPS_LOG2 samples, DATA_W bits each. The pointer
// always addresses the oldest sample, which is also the slot overwritten by
// the next write, so one pointer serves both read and write.
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset, zeroes slots and pointer
//   wr_en_i    : store wr_data_i in the current slot and advance the pointer
//   wr_data_i  : sample to store
//   clr_en_i   : zero the current slot and advance the pointer
//   ptr_rst_i  : return the pointer to slot 0
//   ptr_o      : current pointer
//   oldest_o   : sample in the current slot (the oldest one)
// ---------------------------------------------------------------------------
module ma_delay_line
    import fir_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int TAPS_LOG2 = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [DATA_W-1:0]    wr_data_i,
    input  logic                 clr_en_i,
    input  logic                 ptr_rst_i,
    output logic [TAPS_LOG2-1:0] ptr_o,
    output logic [DATA_W-1:0]    oldest_o
);

    localparam int NUM_TAPS = 1 << TAPS_LOG2;

    logic [DATA_W-1:0]    slot_q [NUM_TAPS];
    logic [TAPS_LOG2-1:0] ptr_q;

    // The pointer steps on every write or clear. Because the tap count is a
    // power of two, the natural binary wrap gives the modulo for free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (ptr_rst_i) begin
            ptr_q <= '0;
        end else if (wr_en_i || clr_en_i) begin
            ptr_q <= ptr_q + 1'b1;
        end
    end

    // Clearing takes priority over writing; the engine never asks for both,
    // but this keeps the clear phase deterministic regardless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (clr_en_i) begin
            slot_q[ptr_q] <= '0;
        end else if (wr_en_i) begin
            slot_q[ptr_q] <= wr_data_i;
        end
    end

    assign ptr_o    = ptr_q;
    assign oldest_o = slot_q[ptr_q];

endmodule

// File: rtl/fir_ma_engine.sv
// ---------------------------------------------------------------------------
// fir_ma_engine
// Moving-average FIR engine with valid/ready handshakes. A start_stop pulse
// in IDLE starts a buffer-clear phase (one slot per cycle), after which the
// engine runs; a pulse in RUN stops it. Each accepted sample updates a
// running sum and produces a registered average one cycle later.
// Ports:
//   CLOCK_50   : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start_stop : one-cycle start/stop toggle request
//   in_valid   : input sample valid
//   in_data    : signed input sample
//   in_ready   : engine accepts in_data this cycle (combinational)
//   out_valid  : out_data holds an unconsumed average
//   out_data   : signed moving average
//   out_ready  : downstream consumes out_data
//   running    : engine is in RUN
//   sample_cnt : samples accepted since the last start (wraps silently)
// Build option: define ROUND_EN to round the average half toward +inf
// instead of flooring it. Latency is the same in both builds.
// ---------------------------------------------------------------------------
module fir_ma_engine
    import fir_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int TAPS_LOG2 = 2,
    parameter int CNT_W     = 36
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              start_stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              running,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int NUM_TAPS = 1 << TAPS_LOG2;
    localparam int SUM_W    = sumWidth(DATA_W, TAPS_LOG2);

    fir_state_e               state_q, state_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic                     outValid_q, outValid_d;
    logic [DATA_W-1:0]        outData_q, outData_d;
    logic [CNT_W-1:0]         sampleCnt_q, sampleCnt_d;

    logic                     accept;
    logic                     enterClear;
    logic [TAPS_LOG2-1:0]     ptr;
    logic [DATA_W-1:0]        oldest;
    logic signed [SUM_W-1:0]  inExt;
    logic signed [SUM_W-1:0]  oldExt;
    logic signed [SUM_W-1:0]  sumNext;
    logic [DATA_W-1:0]        average;

    ma_delay_line #(
        .DATA_W    (DATA_W),
        .TAPS_LOG2 (TAPS_LOG2)
    ) u_delay_line (
        .clk_i     (CLOCK_50),
        .rst_ni    (rst_n),
        .wr_en_i   (accept),
        .wr_data_i (in_data),
        .clr_en_i  (state_q == CLEAR),
        .ptr_rst_i (enterClear),
        .ptr_o     (ptr),
        .oldest_o  (oldest)
    );

    // A stop request blocks acceptance in the same cycle, and a pending
    // output that is not being consumed this cycle stalls the input.
    assign in_ready   = (state_q == RUN) && !start_stop && (!outValid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign enterClear = (state_q == IDLE) && start_stop;

    // Sign-extend both samples to the sum width; the sum can hold TAPS
    // full-scale samples so the add/subtract never overflows.
    assign inExt   = {{TAPS_LOG2{in_data[DATA_W-1]}}, in_data};
    assign oldExt  = {{TAPS_LOG2{oldest[DATA_W-1]}}, oldest};
    assign sumNext = sum_q + inExt - oldExt;

`ifdef ROUND_EN
    localparam int HALF = 1 << (TAPS_LOG2 - 1);
    logic signed [SUM_W:0] rndSum;

    // Adding half an LSB before the floor shift rounds half toward +inf;
    // the extra top bit keeps the addition from wrapping.
    assign rndSum  = {sumNext[SUM_W-1], sumNext} + (SUM_W+1)'(HALF);
    assign average = DATA_W'(rndSum >>> TAPS_LOG2);
`else
    // Arithmetic shift divides by the tap count rounding toward -inf.
    assign average = DATA_W'(sumNext >>> TAPS_LOG2);
`endif

    // Control flow: IDLE waits for a start, CLEAR walks the pointer once
    // around the buffer zeroing slots, RUN processes samples until a stop.
    // Start requests during CLEAR are deliberately ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_stop) state_d = CLEAR;
            CLEAR:   if (ptr == TAPS_LOG2'(NUM_TAPS - 1)) state_d = RUN;
            RUN:     if (start_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state. Entering CLEAR wipes the sum, the counter and any
    // pending output; out_data itself is left alone. A consume and a new
    // accept in the same cycle simply replace the output without a bubble.
    always_comb begin
        sum_d       = sum_q;
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        sampleCnt_d = sampleCnt_q;
        if (enterClear) begin
            sum_d       = '0;
            outValid_d  = 1'b0;
            sampleCnt_d = '0;
        end else if (accept) begin
            sum_d       = sumNext;
            outValid_d  = 1'b1;
            outData_d   = average;
            sampleCnt_d = sampleCnt_q + 1'b1;
        end else if (outValid_q && out_ready) begin
            outValid_d  = 1'b0;
        end
    end

    // All engine state resets asynchronously so a mid-run reset takes
    // effect without waiting for a clock edge.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            sampleCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            sampleCnt_q <= sampleCnt_d;
        end
    end

    assign out_valid  = outValid_q;
    assign out_data   = outData_q;
    assign running    = (state_q == RUN);
    assign sample_cnt = sampleCnt_q;

endmodule

// File: tb/tb_fir_ma_engine.sv
// ---------------------------------------------------------------------------
// tb_fir_ma_engine
// Self-checking bench for fir_ma_engine. Two instances share all inputs: the
// default configuration and one with a 4-bit sample counter so the counter
// wrap is observable. Expected values come from directed constants and from
// a window-of-samples reference model that averages with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_fir_ma_engine;

    localparam int DATA_W    = 8;
    localparam int TAPS_LOG2 = 2;
    localparam int TAPS      = 4;
    localparam int CNT_W     = 36;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_RUN   = 2;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              start_stop = 1'b0;
    logic              in_valid   = 1'b0;
    logic [DATA_W-1:0] in_data    = '0;
    logic              out_ready  = 1'b0;

    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              running;
    logic [CNT_W-1:0]  sample_cnt;

    logic              in_ready4;
    logic              out_valid4;
    logic [DATA_W-1:0] out_data4;
    logic              running4;
    logic [3:0]        sample_cnt4;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model: engine mode, remaining clear cycles, the last TAPS
    // accepted samples, pending output and the accepted-sample count.
    int     mState;
    int     clrLeft;
    int     win[$];
    logic   mOV;
    int     mOD;
    longint mCnt;

    fir_ma_engine #(
        .DATA_W    (DATA_W),
        .TAPS_LOG2 (TAPS_LOG2),
        .CNT_W     (CNT_W)
    ) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .running    (running),
        .sample_cnt (sample_cnt)
    );

    fir_ma_engine #(
        .DATA_W    (DATA_W),
        .TAPS_LOG2 (TAPS_LOG2),
        .CNT_W     (4)
    ) dut4 (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready4),
        .out_valid  (out_valid4),
        .out_data   (out_data4),
        .out_ready  (out_ready),
        .running    (running4),
        .sample_cnt (sample_cnt4)
    );

    // 10 ns clock period
    always #5 clk = ~clk;

    // Mathematical floor division, correct for negative numerators.
    function automatic int floorDiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Average of the current window, floored or rounded half-up.
    function automatic int expectedAvg();
        int s;
        s = 0;
        foreach (win[i]) s += win[i];
`ifdef ROUND_EN
        return floorDiv(s + TAPS / 2, TAPS);
`else
        return floorDiv(s, TAPS);
`endif
    endfunction

    task automatic zeroWindow();
        win.delete();
        for (int i = 0; i < TAPS; i++) win.push_back(0);
    endtask

    task automatic modelReset();
        mState  = M_IDLE;
        clrLeft = 0;
        zeroWindow();
        mOV     = 1'b0;
        mOD     = 0;
        mCnt    = 0;
    endtask

    // Drive one cycle of inputs, clock it, and advance the reference model.
    task automatic applyStimulus(input logic sv, input logic iv,
                                 input logic [DATA_W-1:0] d, input logic ordy);
        logic acc;
        start_stop = sv;
        in_valid   = iv;
        in_data    = d;
        out_ready  = ordy;
        acc = (mState == M_RUN) && !sv && (!mOV || ordy) && iv;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        in_valid   = 1'b0;
        if (acc) begin
            win.push_back(int'($signed(d)));
            void'(win.pop_front());
            mOD  = expectedAvg();
            mOV  = 1'b1;
            mCnt = mCnt + 1;
        end else if (mOV && ordy) begin
            mOV = 1'b0;
        end
        case (mState)
            M_IDLE: if (sv) begin
                mState  = M_CLEAR;
                clrLeft = TAPS;
                zeroWindow();
                mOV     = 1'b0;
                mCnt    = 0;
            end
            M_CLEAR: begin
                clrLeft = clrLeft - 1;
                if (clrLeft == 0) mState = M_RUN;
            end
            default: if (sv) mState = M_IDLE;
        endcase
    endtask

    // Stop if running, then start and sit out the clear phase.
    task automatic restart();
        if (mState == M_RUN) applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        repeat (TAPS) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        #2;
        checkCount++;
        if ({running, out_valid, in_ready, out_data, sample_cnt} !== '0)
            $display("[TB] FAIL reset_outputs got run=%0b ov=%0b rdy=%0b od=%0d cnt=%0d want all 0",
                     running, out_valid, in_ready, out_data, sample_cnt);
        else passCount++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_start_timing();
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        for (int k = 1; k <= TAPS; k++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            checkCount++;
            if (running !== (k == TAPS))
                $display("[TB] FAIL start_running cycle %0d got %0b want %0b", k + 1, running, (k == TAPS));
            else passCount++;
        end
        checkCount++;
        if ({out_valid, out_data, sample_cnt} !== '0)
            $display("[TB] FAIL start_outputs got ov=%0b od=%0d cnt=%0d want 0", out_valid, out_data, sample_cnt);
        else passCount++;
    endtask

    task automatic test_basic_avg();
        int expAvg[5] = '{1, 2, 3, 4, 4};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd4, 1'b1);
            checkCount++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(expAvg[i]))
                $display("[TB] FAIL basic_avg[%0d] got ov=%0b od=%0d want ov=1 od=%0d",
                         i, out_valid, $signed(out_data), expAvg[i]);
            else passCount++;
        end
        checkCount++;
        if (sample_cnt !== 36'd5)
            $display("[TB] FAIL basic_count got %0d want 5", sample_cnt);
        else passCount++;
    endtask

    task automatic test_negative();
        int expNeg[4] = '{-1, -2, -3, -4};
        int expOne;
`ifdef ROUND_EN
        expOne = 0;
`else
        expOne = -1;
`endif
        restart();
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkCount++;
        if (out_data !== DATA_W'(expOne))
            $display("[TB] FAIL neg_single got %0d want %0d", $signed(out_data), expOne);
        else passCount++;
        restart();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 8'hFC, 1'b1);
            checkCount++;
            if (out_data !== DATA_W'(expNeg[i]))
                $display("[TB] FAIL neg_avg[%0d] got %0d want %0d", i, $signed(out_data), expNeg[i]);
            else passCount++;
        end
    endtask

    task automatic test_backpressure();
        restart();
        applyStimulus(1'b0, 1'b1, 8'd4, 1'b0);
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'd4;
            out_ready = 1'b0;
            #1;
            checkCount++;
            if (in_ready !== 1'b0)
                $display("[TB] FAIL bp_in_ready got %0b want 0", in_ready);
            else passCount++;
            applyStimulus(1'b0, 1'b1, 8'd4, 1'b0);
            checkCount++;
            if (out_valid !== 1'b1 || out_data !== 8'd1 || sample_cnt !== 36'd1)
                $display("[TB] FAIL bp_hold got ov=%0b od=%0d cnt=%0d want ov=1 od=1 cnt=1",
                         out_valid, out_data, sample_cnt);
            else passCount++;
        end
        applyStimulus(1'b0, 1'b1, 8'd4, 1'b1);
        checkCount++;
        if (out_valid !== 1'b1 || out_data !== 8'd2 || sample_cnt !== 36'd2)
            $display("[TB] FAIL bp_release got ov=%0b od=%0d cnt=%0d want ov=1 od=2 cnt=2",
                     out_valid, out_data, sample_cnt);
        else passCount++;
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkCount++;
        if (out_valid !== 1'b0)
            $display("[TB] FAIL bp_consumed got ov=%0b want 0", out_valid);
        else passCount++;
    endtask

    task automatic test_stop_restart();
        applyStimulus(1'b1, 1'b1, 8'd8, 1'b1);
        checkCount++;
        if (running !== 1'b0 || sample_cnt !== 36'd2 || out_data !== 8'd2)
            $display("[TB] FAIL stop_reject got run=%0b cnt=%0d od=%0d want run=0 cnt=2 od=2",
                     running, sample_cnt, out_data);
        else passCount++;
        restart();
        checkCount++;
        if (running !== 1'b1 || sample_cnt !== 36'd0)
            $display("[TB] FAIL restart_state got run=%0b cnt=%0d want run=1 cnt=0", running, sample_cnt);
        else passCount++;
        applyStimulus(1'b0, 1'b1, 8'd8, 1'b1);
        checkCount++;
        if (out_data !== 8'd2)
            $display("[TB] FAIL restart_avg got %0d want 2", $signed(out_data));
        else passCount++;
    endtask

    task automatic test_counter_wrap();
        restart();
        repeat (17) applyStimulus(1'b0, 1'b1, DATA_W'($urandom), 1'b1);
        checkCount++;
        if (sample_cnt4 !== 4'd1 || sample_cnt !== 36'd17)
            $display("[TB] FAIL cnt_wrap got cnt4=%0d cnt=%0d want cnt4=1 cnt=17", sample_cnt4, sample_cnt);
        else passCount++;
        checkCount++;
        if (out_data !== DATA_W'(mOD))
            $display("[TB] FAIL cnt_wrap_avg got %0d want %0d", $signed(out_data), mOD);
        else passCount++;
    endtask

    task automatic test_random();
        logic sv, iv, ordy;
        logic [DATA_W-1:0] d;
        logic expRdy;
        restart();
        for (int n = 0; n < 400; n++) begin
            sv   = ($urandom_range(0, 19) == 0);
            iv   = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 2) != 0;
            d    = DATA_W'($urandom);
            start_stop = sv;
            in_valid   = iv;
            in_data    = d;
            out_ready  = ordy;
            #1;
            expRdy = (mState == M_RUN) && !sv && (!mOV || ordy);
            checkCount++;
            if (in_ready !== expRdy)
                $display("[TB] FAIL rnd_in_ready[%0d] got %0b want %0b", n, in_ready, expRdy);
            else passCount++;
            applyStimulus(sv, iv, d, ordy);
            checkCount++;
            if (out_valid !== mOV || out_data !== DATA_W'(mOD) || running !== (mState == M_RUN)
                || sample_cnt !== CNT_W'(mCnt) || sample_cnt4 !== 4'(mCnt))
                $display("[TB] FAIL rnd_state[%0d] got ov=%0b od=%0d run=%0b cnt=%0d cnt4=%0d want ov=%0b od=%0d run=%0b cnt=%0d",
                         n, out_valid, $signed(out_data), running, sample_cnt, sample_cnt4,
                         mOV, mOD, (mState == M_RUN), mCnt);
            else passCount++;
        end
    endtask

    task automatic test_async_reset();
        restart();
        repeat (3) applyStimulus(1'b0, 1'b1, 8'd20, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({running, out_valid, in_ready, out_data, sample_cnt, sample_cnt4, out_valid4} !== '0)
            $display("[TB] FAIL async_reset got run=%0b ov=%0b rdy=%0b od=%0d cnt=%0d cnt4=%0d want all 0",
                     running, out_valid, in_ready, out_data, sample_cnt, sample_cnt4);
        else passCount++;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        restart();
        applyStimulus(1'b0, 1'b1, 8'd12, 1'b1);
        checkCount++;
        if (out_data !== 8'd3 || sample_cnt !== 36'd1)
            $display("[TB] FAIL post_reset got od=%0d cnt=%0d want od=3 cnt=1", $signed(out_data), sample_cnt);
        else passCount++;
    endtask

    // Scenarios run back to back; each leaves the engine in a known state.
    initial begin
        modelReset();
        test_reset();
        test_start_timing();
        test_basic_avg();
        test_negative();
        test_backpressure();
        test_stop_restart();
        test_counter_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
